// File: rtl/addsub_result_fifo.sv
// Result stage behind the 16-bit adder/subtractor: flags, optional saturation, FIFO buffering, overflow stats.
// Latency: an entry pushed at edge k is the head on out_* right after edge k (no pass-through when full).
// Backpressure: in_ready = (count < DEPTH); out_valid = (count != 0); both depend only on registered count.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      producer handshake; s/carry/overflow are sampled on a push edge
//   out_valid/out_ready    consumer handshake; out_data/out_flags show the head entry
//   out_flags              {N,Z,C,V} of the head entry (N/Z taken from the stored data)
//   count                  number of entries held, 0..DEPTH
//   sticky_ovf, ovf_count  overflow statistics; clear_stat clears both synchronously
module addsub_result_fifo #(
  parameter int DEPTH    = 4,     // power of two, 2..16
  parameter bit SATURATE = 1'b0   // 1: clamp data on signed overflow
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              s,
  input  logic                     carry,
  input  logic                     overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
  output logic [7:0]               ovf_count,
  input  logic                     clear_stat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  flags;   // {N,Z,C,V}
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        new_entry;
  logic [15:0]   new_data;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Saturation direction follows the wrapped sign: a negative-looking wrapped
  // result came from positive operands, so it clamps to the positive maximum.
  always_comb begin
    new_data = s;
    if (SATURATE && overflow)
      new_data = s[15] ? 16'h7FFF : 16'h8000;
    new_entry.data  = new_data;
    new_entry.flags = {new_data[15], (new_data == 16'h0000), carry, overflow};
  end

  // Storage is deliberately not reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= new_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An overflow push in the same cycle as clear_stat wins: the stats restart at one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= 8'd0;
    end else if (push && overflow) begin
      sticky_ovf <= 1'b1;
      if (clear_stat)
        ovf_count <= 8'd1;
      else if (ovf_count != 8'hFF)
        ovf_count <= ovf_count + 8'd1;
    end else if (clear_stat) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= 8'd0;
    end
  end

  // Head is forced to zero while empty so the outputs read zero straight out of reset.
  always_comb begin
    out_data  = 16'h0000;
    out_flags = 4'h0;
    if (out_valid) begin
      out_data  = mem[rd_ptr].data;
      out_flags = mem[rd_ptr].flags;
    end
  end

endmodule

// File: tb/tb_addsub_result_fifo.sv
module tb_addsub_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] s;
  logic        carry;
  logic        overflow;
  logic        out_ready;
  logic        clear_stat;

  // Wrapping instance (SATURATE=0)
  logic        in_ready, out_valid, sticky_ovf;
  logic [15:0] out_data;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic [7:0]  ovf_count;

  // Saturating instance (SATURATE=1), same stimulus
  logic        sat_in_ready, sat_out_valid, sat_sticky_ovf;
  logic [15:0] sat_out_data;
  logic [3:0]  sat_out_flags;
  logic [2:0]  sat_count;
  logic [7:0]  sat_ovf_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_result_fifo #(.DEPTH(4), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .carry(carry), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .count(count),
    .sticky_ovf(sticky_ovf), .ovf_count(ovf_count), .clear_stat(clear_stat)
  );

  addsub_result_fifo #(.DEPTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .s(s), .carry(carry), .overflow(overflow),
    .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_data(sat_out_data), .out_flags(sat_out_flags), .count(sat_count),
    .sticky_ovf(sat_sticky_ovf), .ovf_count(sat_ovf_count), .clear_stat(clear_stat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] sv, input logic c, input logic v);
    in_valid = 1'b1; s = sv; carry = c; overflow = v;
    step();
    in_valid = 1'b0;
  endtask

  // Head of both instances plus their counts
  task automatic head(input string tag, input logic [15:0] d, input logic [3:0] f,
                      input logic [15:0] sd, input logic [3:0] sf, input logic [2:0] n);
    check({tag, ".data"},      32'(out_data),      32'(d));
    check({tag, ".flags"},     32'(out_flags),     32'(f));
    check({tag, ".sat_data"},  32'(sat_out_data),  32'(sd));
    check({tag, ".sat_flags"}, 32'(sat_out_flags), 32'(sf));
    check({tag, ".count"},     32'(count),         32'(n));
    check({tag, ".sat_count"}, 32'(sat_count),     32'(n));
  endtask

  task automatic stats(input string tag, input logic st, input logic [7:0] oc);
    check({tag, ".sticky"},     32'(sticky_ovf),     32'(st));
    check({tag, ".ovf_cnt"},    32'(ovf_count),      32'(oc));
    check({tag, ".sat_sticky"}, 32'(sat_sticky_ovf), 32'(st));
    check({tag, ".sat_ovf"},    32'(sat_ovf_count),  32'(oc));
  endtask

  task automatic idle_state(input string tag);
    check({tag, ".count"},     32'(count),     32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_data"},  32'(out_data),  32'd0);
    check({tag, ".out_flags"}, 32'(out_flags), 32'd0);
    check({tag, ".sat_count"}, 32'(sat_count), 32'd0);
    check({tag, ".sat_valid"}, 32'(sat_out_valid), 32'd0);
    check({tag, ".sat_ready"}, 32'(sat_in_ready),  32'd1);
    stats(tag, 1'b0, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; s = 16'h0; carry = 1'b0; overflow = 1'b0;
    out_ready = 1'b0; clear_stat = 1'b0;
    #12;
    idle_state("reset");
    rst_n = 1'b1;
    step();

    // 0xAAAA + 0xFFFF
    push(16'hAAA9, 1'b1, 1'b0);
    check("t1.out_valid", 32'(out_valid), 32'd1);
    head("t1", 16'hAAA9, 4'b1010, 16'hAAA9, 4'b1010, 3'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t1.drained", 32'(out_valid), 32'd0);

    // In-order pop under backpressure
    push(16'hAAAA, 1'b0, 1'b0);
    push(16'hAAAB, 1'b0, 1'b0);
    head("t2.held", 16'hAAAA, 4'b1000, 16'hAAAA, 4'b1000, 3'd2);
    out_ready = 1'b1;
    step();
    head("t2.pop1", 16'hAAAB, 4'b1000, 16'hAAAB, 4'b1000, 3'd1);
    step();
    check("t2.count0", 32'(count), 32'd0);
    check("t2.valid0", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Fill to DEPTH, refused fifth push, simultaneous push/pop at count 3
    for (int i = 1; i <= 4; i++) begin
      check("t3.in_ready_pre", 32'(in_ready), 32'd1);
      push(16'(i), 1'b0, 1'b0);
    end
    check("t3.full_rdy", 32'(in_ready), 32'd0);
    check("t3.sat_full_rdy", 32'(sat_in_ready), 32'd0);
    in_valid = 1'b1; s = 16'h0005;
    step();
    in_valid = 1'b0;
    head("t3.refused", 16'h0001, 4'b0000, 16'h0001, 4'b0000, 3'd4);
    out_ready = 1'b1; step();
    head("t3.pop", 16'h0002, 4'b0000, 16'h0002, 4'b0000, 3'd3);
    check("t3.rdy3", 32'(in_ready), 32'd1);
    in_valid = 1'b1; s = 16'h0006;
    step();
    in_valid = 1'b0;
    head("t3.pushpop", 16'h0003, 4'b0000, 16'h0003, 4'b0000, 3'd3);
    step();
    head("t3.d1", 16'h0004, 4'b0000, 16'h0004, 4'b0000, 3'd2);
    step();
    head("t3.d2", 16'h0006, 4'b0000, 16'h0006, 4'b0000, 3'd1);
    step();
    check("t3.empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Overflow: 0x7FFF + 1 wraps to 0x8000
    push(16'h8000, 1'b0, 1'b1);
    head("t4.pos", 16'h8000, 4'b1001, 16'h7FFF, 4'b0001, 3'd1);
    stats("t4.pos", 1'b1, 8'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    // 0x8000 + 0xFFFF wraps to 0x7FFF with carry
    push(16'h7FFF, 1'b1, 1'b1);
    head("t4.neg", 16'h7FFF, 4'b0011, 16'h8000, 4'b1011, 3'd1);
    stats("t4.neg", 1'b1, 8'd2);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // clear_stat together with an overflow push: push wins, count restarts at 1
    clear_stat = 1'b1;
    push(16'h8000, 1'b0, 1'b1);
    clear_stat = 1'b0;
    stats("t5.clr_push", 1'b1, 8'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // 0x0001 + 0xFFFF = 0 with carry
    push(16'h0000, 1'b1, 1'b0);
    head("t5.zero", 16'h0000, 4'b0110, 16'h0000, 4'b0110, 3'd1);
    stats("t5.zero", 1'b1, 8'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    clear_stat = 1'b1; step(); clear_stat = 1'b0;
    stats("t5.clear", 1'b0, 8'd0);

    // Sustained push+pop: 260 overflow pushes saturate ovf_count at 255
    in_valid = 1'b1; s = 16'h8000; carry = 1'b0; overflow = 1'b1; out_ready = 1'b1;
    repeat (260) step();
    in_valid = 1'b0; overflow = 1'b0;
    head("t6.stream", 16'h8000, 4'b1001, 16'h7FFF, 4'b0001, 3'd1);
    stats("t6.sat", 1'b1, 8'd255);
    step();
    check("t6.drained", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset mid-burst with 3 entries held
    push(16'h1234, 1'b0, 1'b1);
    push(16'h2345, 1'b0, 1'b0);
    push(16'h3456, 1'b0, 1'b0);
    check("t7.count3", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    idle_state("t7.async");
    #2 rst_n = 1'b1;
    step();
    idle_state("t7.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
